// File: rtl/mastermind_scorer_if.sv
// Guess/result bus of the Mastermind scorer: code/guess in over valid/ready,
// scores and game status out over valid/ready.
interface mastermind_scorer_if #(
  parameter int PEGS      = 4,
  parameter int COLOR_W   = 3,
  parameter int MAX_TRIES = 10
);
  localparam int CNT_W = $clog2(PEGS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [PEGS*COLOR_W-1:0]   code;
  logic [PEGS*COLOR_W-1:0]   guess;
  logic                      out_valid;
  logic                      out_ready;
  logic [CNT_W-1:0]          exact;
  logic [CNT_W-1:0]          partial;
  logic [2*PEGS-1:0]         fb;
  logic [TRY_W-1:0]          tries;
  logic                      win;
  logic                      lose;

  modport master (
    output in_valid, code, guess, out_ready,
    input  in_ready, out_valid, exact, partial, fb, tries, win, lose
  );

  modport slave (
    input  in_valid, code, guess, out_ready,
    output in_ready, out_valid, exact, partial, fb, tries, win, lose
  );
endinterface

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: one slot per cycle for exact hits and colour
// histograms, then one colour per cycle to sum min(code, guess) occurrences.
module mastermind_scorer #(
  parameter int PEGS      = 4,
  parameter int COLOR_W   = 3,
  parameter int MAX_TRIES = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  mastermind_scorer_if.slave bus
);
  localparam int NCOL   = 2 ** COLOR_W;
  localparam int CNT_W  = $clog2(PEGS + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int SLOT_W = $clog2(PEGS);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SUM, S_DONE} state_t;

  state_t                  state_r;
  logic [PEGS*COLOR_W-1:0] code_r;
  logic [PEGS*COLOR_W-1:0] guess_r;
  logic [SLOT_W-1:0]       slot_r;
  logic [COLOR_W-1:0]      col_r;
  logic [CNT_W-1:0]        hist_c_r [NCOL];
  logic [CNT_W-1:0]        hist_g_r [NCOL];
  logic [CNT_W-1:0]        exact_r;
  logic [CNT_W-1:0]        partial_r;
  logic [2*PEGS-1:0]       fb_r;
  logic                    out_valid_r;
  logic [TRY_W-1:0]        tries_r;
  logic                    win_r;
  logic                    lose_r;

  logic                    in_ready_s;
  logic [COLOR_W-1:0]      code_slot_s;
  logic [COLOR_W-1:0]      guess_slot_s;
  logic [CNT_W-1:0]        partial_sum_s;
  logic [TRY_W-1:0]        tries_inc_s;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Feedback is sorted: all exact pegs first, then colour-only pegs, then blanks.
  function automatic logic [2*PEGS-1:0] build_fb(input logic [CNT_W-1:0] ex,
                                                  input logic [CNT_W-1:0] pa);
    logic [2*PEGS-1:0] v;
    v = {(2*PEGS){1'b0}};
    for (int k = 0; k < PEGS; k++) begin
      if (k < int'(ex)) begin
        v[2*k +: 2] = 2'd2;
      end else if (k < int'(ex) + int'(pa)) begin
        v[2*k +: 2] = 2'd1;
      end else begin
        v[2*k +: 2] = 2'd0;
      end
    end
    return v;
  endfunction

  // Slot/colour selection, running partial sum and saturating try count.
  always_comb begin
    in_ready_s    = (state_r == S_IDLE) && !win_r && !lose_r;
    code_slot_s   = code_r[slot_r*COLOR_W +: COLOR_W];
    guess_slot_s  = guess_r[slot_r*COLOR_W +: COLOR_W];
    partial_sum_s = partial_r + min_cnt(hist_c_r[col_r], hist_g_r[col_r]);
    if (tries_r == TRY_W'(MAX_TRIES)) begin
      tries_inc_s = tries_r;
    end else begin
      tries_inc_s = tries_r + TRY_W'(1);
    end
  end

  // Scoring FSM with game bookkeeping; new_game overrides any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      code_r      <= {(PEGS*COLOR_W){1'b0}};
      guess_r     <= {(PEGS*COLOR_W){1'b0}};
      slot_r      <= {SLOT_W{1'b0}};
      col_r       <= {COLOR_W{1'b0}};
      exact_r     <= {CNT_W{1'b0}};
      partial_r   <= {CNT_W{1'b0}};
      fb_r        <= {(2*PEGS){1'b0}};
      out_valid_r <= 1'b0;
      tries_r     <= {TRY_W{1'b0}};
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
      for (int c = 0; c < NCOL; c++) begin
        hist_c_r[c] <= {CNT_W{1'b0}};
        hist_g_r[c] <= {CNT_W{1'b0}};
      end
    end else if (new_game) begin
      state_r     <= S_IDLE;
      exact_r     <= {CNT_W{1'b0}};
      partial_r   <= {CNT_W{1'b0}};
      fb_r        <= {(2*PEGS){1'b0}};
      out_valid_r <= 1'b0;
      tries_r     <= {TRY_W{1'b0}};
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid && in_ready_s) begin
            code_r    <= bus.code;
            guess_r   <= bus.guess;
            slot_r    <= {SLOT_W{1'b0}};
            col_r     <= {COLOR_W{1'b0}};
            exact_r   <= {CNT_W{1'b0}};
            partial_r <= {CNT_W{1'b0}};
            fb_r      <= {(2*PEGS){1'b0}};
            for (int c = 0; c < NCOL; c++) begin
              hist_c_r[c] <= {CNT_W{1'b0}};
              hist_g_r[c] <= {CNT_W{1'b0}};
            end
            state_r <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Exact hits are kept out of the histograms so they are never re-counted as partial.
          if (code_slot_s == guess_slot_s) begin
            exact_r <= exact_r + CNT_W'(1);
          end else begin
            hist_c_r[code_slot_s]  <= hist_c_r[code_slot_s] + CNT_W'(1);
            hist_g_r[guess_slot_s] <= hist_g_r[guess_slot_s] + CNT_W'(1);
          end
          if (slot_r == SLOT_W'(PEGS - 1)) begin
            state_r <= S_SUM;
          end else begin
            slot_r <= slot_r + SLOT_W'(1);
          end
        end
        S_SUM: begin
          partial_r <= partial_sum_s;
          if (col_r == COLOR_W'(NCOL - 1)) begin
            fb_r        <= build_fb(exact_r, partial_sum_s);
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            col_r <= col_r + COLOR_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
            tries_r     <= tries_inc_s;
            if (exact_r == CNT_W'(PEGS)) begin
              win_r <= 1'b1;
            end else if (tries_inc_s == TRY_W'(MAX_TRIES)) begin
              lose_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.exact     = exact_r;
  assign bus.partial   = partial_r;
  assign bus.fb        = fb_r;
  assign bus.tries     = tries_r;
  assign bus.win       = win_r;
  assign bus.lose      = lose_r;
endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench for mastermind_scorer at PEGS=4, COLOR_W=3, MAX_TRIES=10.
module tb_mastermind_scorer;
  logic clk;
  logic rst_n;
  logic new_game;
  int   total_cnt;
  int   bad_cnt;

  mastermind_scorer_if #(.PEGS(4), .COLOR_W(3), .MAX_TRIES(10)) bus ();

  mastermind_scorer #(.PEGS(4), .COLOR_W(3), .MAX_TRIES(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .new_game (new_game),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pack4(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  // Present a guess and return once it has been accepted (caller is at cycle T+1).
  task automatic accept(input logic [11:0] c, input logic [11:0] g);
    int n;
    bus.code     = c;
    bus.guess    = g;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.in_ready) check_val("accept_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Score one guess, check latency/result, optionally stall, then handshake.
  task automatic run_guess(input string tag, input logic [11:0] c, input logic [11:0] g,
                           input int ex, input int pa, input int fbx, input int stall);
    int n;
    accept(c, g);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    check_val({tag, "_lat"}, n, 32'd13);
    check_val({tag, "_exact"}, bus.exact, ex);
    check_val({tag, "_partial"}, bus.partial, pa);
    check_val({tag, "_fb"}, bus.fb, fbx);
    if (stall > 0) begin
      logic [3:0] t0;
      t0 = bus.tries;
      for (int i = 0; i < stall; i++) step();
      check_val({tag, "_hold_valid"}, bus.out_valid, 32'd1);
      check_val({tag, "_hold_fb"}, bus.fb, fbx);
      check_val({tag, "_hold_tries"}, bus.tries, t0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_val({tag, "_valid_drop"}, bus.out_valid, 32'd0);
    check_val({tag, "_fb_kept"}, bus.fb, fbx);
  endtask

  initial begin
    total_cnt     = 0;
    bad_cnt       = 0;
    rst_n         = 1'b0;
    new_game      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.code      = 12'd0;
    bus.guess     = 12'd0;
    #12;
    check_val("rst_valid", bus.out_valid, 32'd0);
    check_val("rst_scores", {bus.exact, bus.partial, bus.fb}, 32'd0);
    check_val("rst_game", {bus.tries, bus.win, bus.lose}, 32'd0);
    rst_n = 1'b1;
    step();
    check_val("rst_ready", bus.in_ready, 32'd1);

    run_guess("swap", pack4(1, 1, 2, 2), pack4(2, 2, 1, 1), 0, 4, 'h55, 0);
    check_val("swap_game", {bus.tries, bus.win, bus.lose}, {28'd0, 4'd1, 2'b00} >> 0);
    check_val("swap_ready", bus.in_ready, 32'd1);

    run_guess("dup", pack4(1, 1, 1, 2), pack4(1, 2, 2, 2), 2, 0, 'h0A, 5);
    check_val("dup_tries", bus.tries, 32'd2);

    run_guess("rev", pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 0, 4, 'h55, 0);
    run_guess("mix", pack4(5, 5, 0, 7), pack4(5, 0, 5, 6), 1, 2, 'h16, 0);
    check_val("mix_tries", bus.tries, 32'd4);

    // new_game at T+3 discards the in-flight guess.
    accept(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4));
    step();
    step();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check_val("ng_clear", {bus.out_valid, bus.tries, bus.win, bus.lose, bus.exact, bus.partial, bus.fb}, 32'd0);
    check_val("ng_ready", bus.in_ready, 32'd1);
    for (int i = 0; i < 20; i++) step();
    check_val("ng_no_result", bus.out_valid, 32'd0);

    run_guess("win", pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4, 0, 'hAA, 0);
    check_val("win_flags", {bus.tries, bus.win, bus.lose}, {26'd0, 4'd1, 2'b10});
    check_val("win_ready", bus.in_ready, 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    bus.in_valid = 1'b0;
    check_val("win_ignored", bus.out_valid, 32'd0);

    // Async reset mid-COUNT.
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    run_guess("pre_rst", pack4(3, 3, 3, 3), pack4(3, 4, 4, 4), 1, 0, 'h02, 0);
    accept(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4));
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_val("arst_clear", {bus.out_valid, bus.tries, bus.win, bus.lose, bus.exact, bus.partial, bus.fb}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check_val("arst_ready", bus.in_ready, 32'd1);
    run_guess("post_rst", pack4(6, 7, 0, 1), pack4(7, 6, 0, 2), 1, 2, 'h16, 0);

    // Ten misses lose the game.
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      run_guess("miss", pack4(0, 0, 0, 0), pack4(7, 7, 7, 7), 0, 0, 0, 0);
      check_val("miss_tries", bus.tries, t);
      check_val("miss_lose", bus.lose, (t == 10) ? 32'd1 : 32'd0);
    end
    check_val("lose_win", bus.win, 32'd0);
    check_val("lose_ready", bus.in_ready, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
